// File: rtl/prog_memory.sv
// prog_memory: program store with power-on clear, streamed program load and registered instruction fetch.
module prog_memory #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf,
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
  state_t state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic accept, at_end, finish;
  assign accept = load_valid && state == LOAD;
  assign at_end = ptr == {ADDR_W{1'b1}};
  assign finish = accept && (load_last || at_end);
  assign load_ready = state == LOAD;
  assign busy = state != RUN;
  always_comb begin
    state_next = state;
    ptr_next = ptr;
    case (state)
      CLEAR: begin
        ptr_next = ptr + 1'b1;
        if (at_end) state_next = RUN;
      end
      RUN: if (load_start) begin
        state_next = LOAD;
        ptr_next = '0;
      end
      LOAD: if (accept) begin
        ptr_next = ptr + 1'b1;
        if (finish) state_next = RUN;
      end
      default: state_next = CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      load_done <= 1'b0;
      load_ovf <= 1'b0;
    end else begin
      state <= state_next;
      ptr <= ptr_next;
      instr_valid <= state == RUN && fetch_en;
      if (state == RUN && fetch_en) instruction <= mem[fetch_addr];
      load_done <= finish;
      if (state == RUN && load_start) load_ovf <= 1'b0;
      else if (accept && !load_last && at_end) load_ovf <= 1'b1;
    end
  end
  // Writes are suppressed on a reset edge so an interrupted load leaves no partial word behind.
  always_ff @(posedge clk)
    if (rst_n && (state == CLEAR || accept)) mem[ptr] <= state == CLEAR ? '0 : load_data;
endmodule

// File: tb/tb_prog_memory.sv
// tb_prog_memory: randomized load/fetch traffic checked against an array model of program memory.
module tb_prog_memory;
  localparam int DATA_W = 17;
  localparam int ADDR_W = 6;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_en = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [DATA_W-1:0] instruction;
  logic instr_valid;
  logic load_start = 1'b0;
  logic load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic load_last = 1'b0;
  logic load_ready, load_done, load_ovf, busy;
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] preset [$];
  prog_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instruction(instruction), .instr_valid(instr_valid), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_ovf(load_ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    int n = 0;
    bit ready_seen = 1'b0;
    rst_n = 1'b0;
    fetch_en = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    check("rst_instruction", instruction, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_done", load_done, 0);
    check("rst_ovf", load_ovf, 0);
    while (busy === 1'b1 && n < 200) begin
      if (load_ready !== 1'b0) ready_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    check("clear_len", n, DEPTH);
    check("ready_in_clear", ready_seen, 0);
  endtask
  task automatic fetch(input int a);
    fetch_en = 1'b1;
    fetch_addr = ADDR_W'(a);
    @(negedge clk);
    fetch_en = 1'b0;
    check($sformatf("fetch[%0d]", a), instruction, mem_m[a]);
    check("fetch_valid", instr_valid, 1);
  endtask
  task automatic do_load(input int n, input bit use_last, input int gap, input bit with_fetch, input int abort_at);
    logic [DATA_W-1:0] old1 = mem_m[1];
    bit done_exp;
    load_start = 1'b1;
    fetch_en = with_fetch;
    fetch_addr = 6'd1;
    @(negedge clk);
    load_start = 1'b0;
    fetch_en = 1'b0;
    check("ready_start", load_ready, 1);
    check("busy_start", busy, 1);
    check("ovf_cleared", load_ovf, 0);
    check("valid_start", instr_valid, with_fetch);
    if (with_fetch) check("fetch_old", instruction, old1);
    for (int i = 0; i < n; i++) begin
      int g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        load_valid = 1'b0;
        fetch_en = 1'($urandom_range(0, 1));
        load_start = 1'($urandom_range(0, 1));
        load_data = DATA_W'($urandom);
        @(negedge clk);
        check("ready_gap", load_ready, 1);
        check("valid_gap", instr_valid, 0);
        check("done_gap", load_done, 0);
      end
      fetch_en = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data = preset.size() > 0 ? preset.pop_front() : DATA_W'($urandom);
      load_last = use_last && i == n - 1;
      @(negedge clk);
      mem_m[i] = load_data;
      load_valid = 1'b0;
      load_last = 1'b0;
      done_exp = i == n - 1 && (use_last || n == DEPTH);
      check("load_done", load_done, done_exp);
      check("ready_after", load_ready, !done_exp);
      if (abort_at == i) begin
        do_reset();
        return;
      end
    end
    check("load_ovf", load_ovf, !use_last && n == DEPTH);
    @(negedge clk);
    check("done_pulse_end", load_done, 0);
    check("busy_end", busy, 0);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) fetch($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    check("idle_valid", instr_valid, 0);
    preset = '{17'h00678, 17'h00796, 17'h00897};
    do_load(3, 1'b1, 0, 1'b0, -1);
    for (int a = 0; a < 4; a++) fetch(a);
    preset = '{17'h00678, 17'h00796, 17'h00897};
    do_load(3, 1'b1, 3, 1'b0, -1);
    for (int a = 0; a < 4; a++) fetch(a);
    do_load(10, 1'b1, -1, 1'b0, -1);
    for (int i = 0; i < 12; i++) fetch($urandom_range(0, 11));
    do_load(DEPTH, 1'b0, 0, 1'b0, -1);
    check("ovf_sticky", load_ovf, 1);
    for (int i = 0; i < 8; i++) fetch($urandom_range(0, DEPTH - 1));
    check("ovf_still", load_ovf, 1);
    do_load(5, 1'b1, -1, 1'b1, -1);
    for (int a = 0; a < 7; a++) fetch(a);
    do_load(5, 1'b1, 0, 1'b0, 1);
    for (int i = 0; i < 8; i++) fetch($urandom_range(0, DEPTH - 1));
    fetch(0);
    fetch(DEPTH - 1);
    check("ovf_after_reset", load_ovf, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_memory.md
PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 17, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port fetch_en  input  1  fetch request; IR enable from the control unit.
REQ-006 SHALL have port fetch_addr  input  ADDR_W  fetch address (PC).
REQ-007 SHALL have port instruction  output  DATA_W  registered fetched word.
REQ-008 SHALL have port instr_valid  output  1  instruction updated by the previous cycle's accepted fetch.
REQ-009 SHALL have port load_start  input  1  pulse requesting a program load.
REQ-010 SHALL have port load_valid  input  1  load_data is valid.
REQ-011 SHALL have port load_data  input  DATA_W  program word to write.
REQ-012 SHALL have port load_last  input  1  marks the final word of a load.
REQ-013 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse at load completion.
REQ-015 SHALL have port load_ovf  output  1  sticky flag: load filled DEPTH words without load_last.
REQ-016 SHALL have port busy  output  1  high whenever state is not RUN.

Function
REQ-017 SHALL implement a three-state FSM: CLEAR, RUN, LOAD.
REQ-018 In CLEAR, SHALL write zero to mem[ptr] each cycle with ptr 0..DEPTH-1, then enter RUN on the cycle after writing DEPTH-1; CLEAR lasts exactly DEPTH cycles.
REQ-019 In RUN with fetch_en=1, SHALL register instruction <= mem[fetch_addr] and set instr_valid=1 the next cycle (1-cycle latency).
REQ-020 In RUN with fetch_en=0, and in CLEAR or LOAD regardless of fetch_en, SHALL hold instruction and drive instr_valid=0 next cycle.
REQ-021 In RUN, load_start=1 SHALL enter LOAD next cycle with ptr=0 and clear load_ovf; load_start in CLEAR or LOAD SHALL be ignored.
REQ-022 Simultaneous load_start and fetch_en in RUN SHALL serve the fetch from pre-load contents and still enter LOAD.
REQ-023 load_ready SHALL equal 1 exactly when state is LOAD (combinational from state).
REQ-024 A load word is accepted when load_valid and load_ready are both 1: mem[ptr] <= load_data, ptr <= ptr+1.
REQ-025 Accepting a word with load_last=1 SHALL return to RUN and pulse load_done for one cycle.
REQ-026 Accepting a word at ptr=DEPTH-1 with load_last=0 SHALL return to RUN, pulse load_done and set load_ovf; ptr never wraps within a load.
REQ-027 In LOAD with load_valid=0, SHALL hold state and ptr indefinitely.
REQ-028 Memory words not written during a load SHALL retain prior contents.
REQ-029 Memory SHALL be writable only via CLEAR or an accepted load word.

Reset
REQ-030 rst_n=0 at a clock edge SHALL set state=CLEAR, ptr=0, instruction=0, instr_valid=0, load_done=0, load_ovf=0.
REQ-031 Reset asserted mid-LOAD or mid-CLEAR SHALL abandon the operation; the subsequent CLEAR zeroes all DEPTH words.
REQ-032 busy=1 and load_ready=0 SHALL hold during and directly after reset until CLEAR completes.

Verification
REQ-033 Reset release, defaults -> busy=1 for 64 cycles, then busy=0; fetch of any address returns 0 with instr_valid=1 one cycle later.
REQ-034 load_start, then words 0x00678,0x00796,0x00897 with last on third -> load_done pulses once; fetch addrs 0,1,2 return those values; addr 3 returns 0.
REQ-035 Load with load_valid gaps of 3 idle cycles between words -> ptr and state hold; final contents identical to gapless load.
REQ-036 Load 64 words without load_last -> returns to RUN after 64th, load_ovf=1, load_done pulses; next load_start clears load_ovf.
REQ-037 load_start with fetch_en, fetch_addr=1 in same RUN cycle -> instruction shows old mem[1], instr_valid=1, busy=1 next cycle.
REQ-038 rst_n low for one cycle after second load word -> 64-cycle CLEAR, all fetches return 0, load_ovf=0.
